// File: rtl/ram_access_arbiter_pkg.sv
// Shared sequencer types and constants for the instruction RAM arbiter.
// Holds the arbiter state enum and the load-path half-word swap.
package ram_access_arbiter_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 1024;

  typedef enum logic [1:0] {
    RUN,
    TO_PROG,
    PROG,
    TO_RUN
  } arb_state_t;

  function automatic logic [RAM_DATA_W-1:0] hw_swap(
    input logic [RAM_DATA_W-1:0] w
  );
    return {w[RAM_DATA_W/2-1:0],
            w[RAM_DATA_W-1:RAM_DATA_W/2]};
  endfunction

endpackage

// File: rtl/ram_readback_slot.sv
// One-deep host readback slot: pending address, grant and data strobe.
// The strobe follows the grant by one cycle, matching the RAM latency.
module ram_readback_slot #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rb_req,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              allow,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              grant,
  output logic [ADDR_W-1:0] grant_addr,
  output logic              rb_valid,
  output logic [DATA_W-1:0] rb_data
);

  logic pend;

  // Pending stays set through the strobe so no second grant can slip in.
  assign grant   = pend & allow & ~rb_valid;
  assign rb_data = rb_valid ? ram_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      grant_addr <= '0;
      rb_valid   <= 1'b0;
    end else begin
      rb_valid <= grant;
      if (rb_valid) begin
        pend <= 1'b0;
      end else if (rb_req && !pend) begin
        pend       <= 1'b1;
        grant_addr <= rb_addr;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Single-port instruction RAM arbiter: loader, parser and host readback.
// Readback path present only when RAM_READBACK_EN is defined.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              sys_clock,
  input  logic              i_reset_n,
  input  logic              i_write_mode,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ready,
  input  logic              i_parse_en,
  input  logic [ADDR_W-1:0] i_parse_addr,
  output logic [DATA_W-1:0] o_parse_data,
  input  logic              i_rb_req,
  input  logic [ADDR_W-1:0] i_rb_addr,
  output logic              o_rb_valid,
  output logic [DATA_W-1:0] o_rb_data,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_load_overflow,
  output logic              o_busy
);

  arb_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              in_prog;
  logic              full;
  logic              accept;

  assign in_prog         = (state == PROG);
  assign full            = count[ADDR_W];
  assign accept          = i_load_valid & in_prog;
  assign o_load_ready    = in_prog;
  assign o_ram_we        = accept & ~full;
  assign o_parse_data    = i_ram_dout;
  assign o_busy          = (state != RUN);
  assign o_load_count    = count;
  assign o_load_overflow = ovf;

  if (DATA_W == RAM_DATA_W) begin : g_pkg_swap
    assign o_ram_din = hw_swap(i_load_data);
  end else begin : g_swap
    assign o_ram_din = {i_load_data[DATA_W/2-1:0],
                        i_load_data[DATA_W-1:DATA_W/2]};
  end

  always_ff @(posedge sys_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= RUN;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (i_write_mode) state <= TO_PROG;
        end
        TO_PROG: begin
          state  <= PROG;
          wr_ptr <= '0;
          count  <= '0;
          ovf    <= 1'b0;
        end
        PROG: begin
          if (accept) begin
            if (full) begin
              ovf <= 1'b1;
            end else begin
              count <= count + 1'b1;
              // Pointer parks on the last word instead of wrapping.
              if (!(&wr_ptr)) wr_ptr <= wr_ptr + 1'b1;
            end
          end
          if (!i_write_mode) state <= TO_RUN;
        end
        TO_RUN: begin
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef RAM_READBACK_EN
  logic              rb_allow;
  logic              rb_grant;
  logic [ADDR_W-1:0] rb_addr_q;

  assign rb_allow = ((state == RUN) & ~i_parse_en) |
                    (in_prog & ~i_load_valid);

  ram_readback_slot #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rb (
    .clk       (sys_clock),
    .rst_n     (i_reset_n),
    .rb_req    (i_rb_req),
    .rb_addr   (i_rb_addr),
    .allow     (rb_allow),
    .ram_dout  (i_ram_dout),
    .grant     (rb_grant),
    .grant_addr(rb_addr_q),
    .rb_valid  (o_rb_valid),
    .rb_data   (o_rb_data)
  );

  assign o_ram_addr = rb_grant ? rb_addr_q :
                      in_prog  ? wr_ptr    : i_parse_addr;
`else
  logic unused_rb;

  assign unused_rb  = ^{i_rb_req, i_rb_addr, i_parse_en};
  assign o_rb_valid = 1'b0;
  assign o_rb_data  = '0;
  assign o_ram_addr = in_prog ? wr_ptr : i_parse_addr;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a 1-cycle RAM model.
// Readback checks adapt to RAM_READBACK_EN.
module tb_ram_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wm;
  logic        lv;
  logic [31:0] ld;
  logic        rdy;
  logic        pe;
  logic [9:0]  pa;
  logic [31:0] pd;
  logic        rb_req;
  logic [9:0]  rb_addr;
  logic        rb_valid;
  logic [31:0] rb_data;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [10:0] cnt;
  logic        ovf;
  logic        busy;

  logic [31:0] mem [1024];

  int n_checks = 0;
  int n_err = 0;

  ram_access_arbiter dut (
    .sys_clock      (clk),
    .i_reset_n      (rst_n),
    .i_write_mode   (wm),
    .i_load_valid   (lv),
    .i_load_data    (ld),
    .o_load_ready   (rdy),
    .i_parse_en     (pe),
    .i_parse_addr   (pa),
    .o_parse_data   (pd),
    .i_rb_req       (rb_req),
    .i_rb_addr      (rb_addr),
    .o_rb_valid     (rb_valid),
    .o_rb_data      (rb_data),
    .o_ram_we       (ram_we),
    .o_ram_addr     (ram_addr),
    .o_ram_din      (ram_din),
    .i_ram_dout     (ram_dout),
    .o_load_count   (cnt),
    .o_load_overflow(ovf),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        wm, lv, pe;
    logic [31:0] ld;
    logic [9:0]  pa;
    logic        busy, rdy, we;
    logic [9:0]  addr;
    logic        chk_din;
    logic [31:0] din;
    logic [10:0] cnt;
    logic        chk_pd;
    logic [31:0] pd;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_in();
    wm = 0; lv = 0; ld = 0; pe = 0; pa = 0;
    rb_req = 0; rb_addr = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rdy"}, {31'd0, rdy}, 0);
    chk({tag, " we"}, {31'd0, ram_we}, 0);
    chk({tag, " busy"}, {31'd0, busy}, 0);
    chk({tag, " cnt"}, {21'd0, cnt}, 0);
    chk({tag, " ovf"}, {31'd0, ovf}, 0);
    chk({tag, " rbv"}, {31'd0, rb_valid}, 0);
    chk({tag, " rbd"}, rb_data, 0);
    chk({tag, " addr"}, {22'd0, ram_addr}, {22'd0, pa});
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    pa = 10'd17;
    tbl[0]  = '{0,0,1, 32'h0,        5, 0,0,0, 5, 0, 0,            0, 0, 0};
    tbl[1]  = '{1,1,1, 32'h11112222, 6, 0,0,0, 6, 0, 0,            0, 0, 0};
    tbl[2]  = '{1,1,0, 32'h11112222, 7, 1,0,0, 7, 0, 0,            0, 0, 0};
    tbl[3]  = '{1,1,0, 32'h11112222, 7, 1,1,1, 0, 1, 32'h22221111, 0, 0, 0};
    tbl[4]  = '{1,1,0, 32'h33334444, 7, 1,1,1, 1, 1, 32'h44443333, 1, 0, 0};
    tbl[5]  = '{1,1,0, 32'h55556666, 7, 1,1,1, 2, 1, 32'h66665555, 2, 0, 0};
    tbl[6]  = '{1,0,0, 32'h0,        7, 1,1,0, 3, 0, 0,            3, 0, 0};
    tbl[7]  = '{0,0,0, 32'h0,        7, 1,1,0, 3, 0, 0,            3, 0, 0};
    tbl[8]  = '{0,1,0, 32'h77778888, 9, 1,0,0, 9, 0, 0,            3, 0, 0};
    tbl[9]  = '{0,0,1, 32'h0,        2, 0,0,0, 2, 0, 0,            3, 0, 0};
    tbl[10] = '{0,0,1, 32'h0,        1, 0,0,0, 1, 0, 0,            3, 1, 32'h66665555};
    tbl[11] = '{0,0,1, 32'h0,        0, 0,0,0, 0, 0, 0,            3, 1, 32'h44443333};
    tbl[12] = '{0,0,1, 32'h0,        0, 0,0,0, 0, 0, 0,            3, 1, 32'h22221111};

    #1;
    chk_reset_vals("por");
    cyc(); cyc();
    rst_n = 1;

    // Mode entry, three swapped writes, exit and parser fetch.
    for (int i = 0; i < 13; i++) begin
      wm = tbl[i].wm; lv = tbl[i].lv; pe = tbl[i].pe;
      ld = tbl[i].ld; pa = tbl[i].pa;
      #1;
      chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("v%0d rdy", i), {31'd0, rdy}, {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d we", i), {31'd0, ram_we}, {31'd0, tbl[i].we});
      chk($sformatf("v%0d addr", i), {22'd0, ram_addr}, {22'd0, tbl[i].addr});
      chk($sformatf("v%0d cnt", i), {21'd0, cnt}, {21'd0, tbl[i].cnt});
      chk($sformatf("v%0d ovf", i), {31'd0, ovf}, 0);
      if (tbl[i].chk_din) chk($sformatf("v%0d din", i), ram_din, tbl[i].din);
      if (tbl[i].chk_pd) chk($sformatf("v%0d pd", i), pd, tbl[i].pd);
      cyc();
    end

    // Overflow: 1026 words into a 1024-word RAM.
    idle_in();
    wm = 1; cyc(); cyc();
    for (int k = 1; k <= 1026; k++) begin
      lv = 1; ld = k;
      #1;
      if (k == 1024) begin
        chk("ovf w1024 we", {31'd0, ram_we}, 1);
        chk("ovf w1024 addr", {22'd0, ram_addr}, 1023);
      end
      if (k == 1025) begin
        chk("ovf w1025 we", {31'd0, ram_we}, 0);
        chk("ovf w1025 rdy", {31'd0, rdy}, 1);
      end
      if (k == 1026) chk("ovf w1026 flag", {31'd0, ovf}, 1);
      cyc();
    end
    lv = 0; ld = 0;
    #1;
    chk("ovf cnt", {21'd0, cnt}, 1024);
    chk("ovf flag", {31'd0, ovf}, 1);
    chk("ovf mem1023", mem[1023], 32'h04000000);
    chk("ovf mem0", mem[0], 32'h00010000);
    wm = 0; cyc(); cyc();
    #1;
    chk("ovf sticky run", {31'd0, ovf}, 1);
    wm = 1; cyc(); cyc();
    #1;
    chk("reentry cnt", {21'd0, cnt}, 0);
    chk("reentry ovf", {31'd0, ovf}, 0);
    chk("reentry rdy", {31'd0, rdy}, 1);

    // Readback of addr 2 held off by four loader cycles.
    for (int i = 0; i < 4; i++) begin
      lv = 1; ld = 32'hA0A00000 | i;
      rb_req = (i == 0); rb_addr = 2;
      #1;
      chk($sformatf("rbp%0d rbv", i), {31'd0, rb_valid}, 0);
      chk($sformatf("rbp%0d addr", i), {22'd0, ram_addr}, i);
      cyc();
    end
    lv = 0; ld = 0; rb_req = 0; rb_addr = 0;
    #1;
    chk("rbp grant rbv", {31'd0, rb_valid}, 0);
`ifdef RAM_READBACK_EN
    chk("rbp grant addr", {22'd0, ram_addr}, 2);
`else
    chk("rbp grant addr", {22'd0, ram_addr}, 4);
`endif
    cyc();
    #1;
`ifdef RAM_READBACK_EN
    chk("rbp strobe", {31'd0, rb_valid}, 1);
    chk("rbp data", rb_data, 32'h0002A0A0);
`else
    chk("rbp strobe", {31'd0, rb_valid}, 0);
    chk("rbp data", rb_data, 0);
`endif
    cyc();
    #1;
    chk("rbp after", {31'd0, rb_valid}, 0);
    wm = 0; cyc(); cyc();

    // Readback in RUN waits for the parser to go idle.
    pe = 1; pa = 0; rb_req = 1; rb_addr = 1;
    #1;
    chk("rbr0 addr", {22'd0, ram_addr}, 0);
    cyc();
    rb_req = 0; pa = 1;
    #1;
    chk("rbr1 pd", pd, 32'h0000A0A0);
    chk("rbr1 rbv", {31'd0, rb_valid}, 0);
    chk("rbr1 addr", {22'd0, ram_addr}, 1);
    cyc();
    pa = 3;
    #1;
    chk("rbr2 pd", pd, 32'h0001A0A0);
    chk("rbr2 rbv", {31'd0, rb_valid}, 0);
    cyc();
    pe = 0;
    #1;
    chk("rbr3 pd", pd, 32'h0003A0A0);
    chk("rbr3 rbv", {31'd0, rb_valid}, 0);
`ifdef RAM_READBACK_EN
    chk("rbr3 addr", {22'd0, ram_addr}, 1);
`else
    chk("rbr3 addr", {22'd0, ram_addr}, 3);
`endif
    cyc();
    #1;
`ifdef RAM_READBACK_EN
    chk("rbr4 strobe", {31'd0, rb_valid}, 1);
    chk("rbr4 data", rb_data, 32'h0001A0A0);
`else
    chk("rbr4 strobe", {31'd0, rb_valid}, 0);
    chk("rbr4 data", rb_data, 0);
`endif
    cyc();
    #1;
    chk("rbr5 rbv", {31'd0, rb_valid}, 0);

    // One-cycle write_mode pulse with the loader valid throughout.
    idle_in();
    wm = 1; lv = 1; ld = 32'hDEADBEEF;
    #1;
    chk("pulse0 busy", {31'd0, busy}, 0);
    chk("pulse0 we", {31'd0, ram_we}, 0);
    cyc();
    wm = 0;
    #1;
    chk("pulse1 busy", {31'd0, busy}, 1);
    chk("pulse1 rdy", {31'd0, rdy}, 0);
    chk("pulse1 we", {31'd0, ram_we}, 0);
    cyc();
    #1;
    chk("pulse2 rdy", {31'd0, rdy}, 1);
    chk("pulse2 we", {31'd0, ram_we}, 1);
    chk("pulse2 addr", {22'd0, ram_addr}, 0);
    chk("pulse2 din", ram_din, 32'hBEEFDEAD);
    cyc();
    #1;
    chk("pulse3 busy", {31'd0, busy}, 1);
    chk("pulse3 rdy", {31'd0, rdy}, 0);
    chk("pulse3 we", {31'd0, ram_we}, 0);
    cyc();
    #1;
    chk("pulse4 busy", {31'd0, busy}, 0);
    chk("pulse4 cnt", {21'd0, cnt}, 1);
    chk("pulse4 mem0", mem[0], 32'hBEEFDEAD);

    // Asynchronous reset in the middle of a PROG cycle.
    idle_in();
    wm = 1; cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      lv = 1; ld = 32'h100 + i;
      cyc();
    end
    pa = 10'd44;
    #1;
    chk("mid cnt before", {21'd0, cnt}, 5);
    #1;
    rst_n = 0;
    #1;
    chk_reset_vals("mid");
    cyc();
    idle_in();
    rst_n = 1;
    cyc();
    #1;
    chk("mid post busy", {31'd0, busy}, 0);
    chk("mid post cnt", {21'd0, cnt}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
